mult_accum_2sc: RTL
===================

// Module: mult_accum_2sC
// PURPOSE
//   Downstream consumer of the pipelined 8x8 two's-complement multiplier.
//   Sums a frame of signed 16-bit products into a saturating ACC_W-bit
//   accumulator (dot-product / FIR tap sum).
//   Delivers one result per frame through a valid/ready output handshake.
//   Applies backpressure upstream while a result is waiting to be taken.
// PARAMETERS
//   IN_W   16  width of the signed product input (multiplier y)
//   ACC_W  24  width of the signed accumulator and result; ACC_W > IN_W
//   CNT_W   9  width of the term counter; saturates at 2^CNT_W-1
// PORTS
//   clk        in   1      single clock; all state updates on posedge clk
//   reset      in   1      synchronous, active-low (reset==0 resets on posedge clk)
//   in_data    in   IN_W   signed product term (two's complement)
//   in_valid   in   1      in_data/in_last are valid this cycle
//   in_last    in   1      this term closes the current frame
//   in_ready   out  1      block accepts a term this cycle
//   out_data   out  ACC_W  signed frame sum, saturated
//   out_count  out  CNT_W  number of terms accepted in the frame (saturating)
//   out_sat    out  1      sticky: saturation occurred at any point in the frame
//   out_valid  out  1      result outputs are valid
//   out_ready  in   1      downstream takes the result
// BEHAVIOUR
//   Reset: state=IDLE, acc=0, cnt=0, sat=0.
//     Reset values: out_valid=0, out_data=0, out_count=0, out_sat=0.
//     in_ready=1 from the first cycle after reset.
//     Reset asserted mid-frame or in HOLD discards all partial and pending data.
//   States:
//     IDLE  - no terms accepted yet.
//     ACCUM - at least 1 term accepted, no in_last yet.
//     HOLD  - result presented on the outputs.
//   in_ready = (state != HOLD); combinational from state only.
//   Accept = in_valid & in_ready. Terms offered while in_ready=0 are ignored and not counted.
//   On accept:
//     sum = sext(acc, ACC_W+1) + sext(in_data, ACC_W+1)
//     sum >  2^(ACC_W-1)-1  -> acc = max positive, sat = 1
//     sum < -2^(ACC_W-1)    -> acc = min negative, sat = 1
//     otherwise             -> acc = sum[ACC_W-1:0]
//     Saturating arithmetic: later terms add to the clamped value.
//     cnt = cnt+1, holding at 2^CNT_W-1 (does not set sat).
//   Transitions on accept:
//     in_last=0: IDLE->ACCUM, ACCUM->ACCUM.
//     in_last=1: load out_data/out_count/out_sat with the values after this term,
//       set out_valid=1, go to HOLD. Single-term frames are allowed.
//   Latency: last term accepted at edge k -> out_valid=1 in the cycle after edge k.
//   HOLD:
//     out_* stable while out_valid & ~out_ready.
//     On out_valid & out_ready at edge j: out_valid=0, acc/cnt/sat cleared, state=IDLE.
//     in_ready=1 from the cycle after edge j. No same-cycle bypass.
//     Max throughput: 1 frame per (terms + 1) cycles.
//   out_data/out_count/out_sat keep the last result after the handshake
//     and change only when the next frame ends.
//   in_last is ignored unless accompanied by an accept.
// TESTING (default parameters unless stated)
//   1. Terms 16'h0100, 16'hFF00, 16'h3F01 (last), out_ready=1
//      -> out_data=24'h003F01, out_count=3, out_sat=0, out_valid high for 1 cycle.
//   2. 300 terms of 16'h7FFF, last on the 300th -> out_data=24'h7FFFFF, out_sat=1, out_count=300.
//      300 terms of 16'h8000 -> out_data=24'h800000, out_sat=1.
//   3. Single term 16'hFFFB (last), out_ready=0 for 5 cycles with in_valid=1 held
//      -> out_data=24'hFFFFFB stable and in_ready=0 throughout.
//      After out_ready=1: next frame count starts at 0; the ignored terms are not counted.
//   4. Two terms of 16'h0010, then reset=0 for 1 cycle
//      -> all outputs 0, in_ready=1.
//      Then 16'h0005 (last) -> out_data=5, out_count=1, out_sat=0.
//   5. Back-to-back single-term frames with in_valid=1 and out_ready=1 held
//      -> in_ready alternates 1/0, out_valid alternates 0/1, every result is correct.
//   6. CNT_W=4, 20 terms of 16'h0001 -> out_count=15, out_data=20, out_sat=0.

Source files
------------

// File: rtl/mult_accum_2sc.sv
// ----------------------------------------------------------------------------
// mult_accum_2sc
//
// Purpose
//   Frame accumulator that sits after the pipelined 8x8 two's-complement
//   multiplier. Signed product terms are summed into a saturating ACC_W-bit
//   accumulator. When the term flagged in_last is accepted, the frame result
//   is presented on the output through a valid/ready handshake. While that
//   result waits to be taken, in_ready is held low so the upstream stalls.
//
// Parameters
//   IN_W   width of the signed product input
//   ACC_W  width of the signed accumulator and result (ACC_W > IN_W)
//   CNT_W  width of the term counter, which saturates at 2^CNT_W-1
//
// Ports
//   clk        clock; all state changes on its rising edge
//   reset      synchronous reset, active low
//   in_data    signed product term
//   in_valid   in_data / in_last are valid this cycle
//   in_last    this term closes the current frame
//   in_ready   a term is accepted this cycle (low only while a result waits)
//   out_data   saturated signed frame sum
//   out_count  number of terms accepted in the frame (saturating)
//   out_sat    saturation occurred at some point in the frame
//   out_valid  result outputs are valid
//   out_ready  downstream takes the result
// ----------------------------------------------------------------------------
module mult_accum_2sc #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 24,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_sat_q, out_sat_d;

  // Arithmetic for the term offered this cycle
  logic             accept;
  logic [ACC_W:0]   sum;
  logic             ovf_pos;
  logic             ovf_neg;
  logic [ACC_W-1:0] acc_upd;
  logic [CNT_W-1:0] cnt_upd;
  logic             sat_upd;

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid & in_ready;

  // One guard bit above the accumulator: the sum of an ACC_W-bit and an
  // IN_W-bit signed value always fits in ACC_W+1 bits, so the two top bits
  // disagreeing is exactly the out-of-range condition.
  assign sum = {acc_q[ACC_W-1], acc_q}
             + {{(ACC_W+1-IN_W){in_data[IN_W-1]}}, in_data};

  assign ovf_pos = ~sum[ACC_W] &  sum[ACC_W-1];
  assign ovf_neg =  sum[ACC_W] & ~sum[ACC_W-1];

  always_comb begin
    acc_upd = sum[ACC_W-1:0];
    if (ovf_pos) begin
      acc_upd = ACC_MAX;
    end else if (ovf_neg) begin
      acc_upd = ACC_MIN;
    end
  end

  assign sat_upd = sat_q | ovf_pos | ovf_neg;
  // Counter pins at all-ones; that is not an arithmetic saturation event.
  assign cnt_upd = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d = acc_upd;
          cnt_d = cnt_upd;
          sat_d = sat_upd;
          if (in_last) begin
            out_data_d  = acc_upd;
            out_count_d = cnt_upd;
            out_sat_d   = sat_upd;
            state_d     = HOLD;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        // Result registers are left untouched so they keep the last frame.
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        sat_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;

endmodule
